// File: rtl/gs_butterfly.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | poly_arith_pkg / gs_butterfly                                            |
// |                                                                          |
// | Pipelined Gentleman-Sande butterfly for the ML-KEM inverse NTT.          |
// | For each accepted (a, b, zeta) it produces                               |
// |    a_o = (a + b) mod Q                                                   |
// |    b_o = zeta * (b - a) mod Q                                            |
// | The modulus is Q = 3329. The block accepts one butterfly per cycle, has  |
// | a fixed four-cycle latency and applies no backpressure.                  |
// |                                                                          |
// | Ports                                                                    |
// |    clk      : clock, every state update is on its rising edge           |
// |    rst      : synchronous, active-low reset                              |
// |    a_i      : upper operand, canonical [0, Q-1]                          |
// |    b_i      : lower operand, canonical [0, Q-1]                          |
// |    zeta_i   : twiddle factor, canonical [0, Q-1]                         |
// |    valid_i  : qualifies a_i / b_i / zeta_i                               |
// |    a_o      : (a + b) mod Q, holds its value between results            |
// |    b_o      : zeta * (b - a) mod Q, holds its value between results     |
// |    valid_o  : one-cycle pulse per accepted input                         |
// |                                                                          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+

package poly_arith_pkg;
   localparam int unsigned Q = 3329;
   typedef logic [11:0] coeff_t;
endpackage

module gs_butterfly
   import poly_arith_pkg::*;
#(
   parameter int unsigned LATENCY   = 4,
   parameter int unsigned BARRETT_M = 5039
) (
   input  logic   clk,
   input  logic   rst,
   input  coeff_t a_i,
   input  coeff_t b_i,
   input  coeff_t zeta_i,
   input  logic   valid_i,
   output coeff_t a_o,
   output coeff_t b_o,
   output logic   valid_o
);

   localparam logic [12:0] c_Q13 = 13'(Q);
   localparam logic [11:0] c_Q12 = 12'(Q);
   localparam logic [12:0] c_M   = 13'(BARRETT_M);

   // ---------------------------------------------------------------------
   // S1: modular add and subtract
   // ---------------------------------------------------------------------
   logic        v1_q;
   coeff_t      sum1_q, sum1_d;
   coeff_t      diff1_q, diff1_d;
   coeff_t      zeta1_q;
   logic [12:0] w_sum;
   logic [12:0] w_diff;

   always_comb begin
      w_sum  = {1'b0, a_i} + {1'b0, b_i};
      // b - a in 13-bit two's complement; bit 12 set means negative.
      w_diff = {1'b0, b_i} - {1'b0, a_i};
      sum1_d  = (w_sum >= c_Q13) ? 12'(w_sum - c_Q13) : 12'(w_sum);
      diff1_d = w_diff[12] ? 12'(w_diff + c_Q13) : 12'(w_diff);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         v1_q    <= 1'b0;
         sum1_q  <= '0;
         diff1_q <= '0;
         zeta1_q <= '0;
      end else begin
         v1_q <= valid_i;
         if (valid_i) begin
            sum1_q  <= sum1_d;
            diff1_q <= diff1_d;
            zeta1_q <= zeta_i;
         end
      end
   end

   // ---------------------------------------------------------------------
   // S2: plain 12x12 multiply; the product never exceeds 3328^2 < 2^24
   // ---------------------------------------------------------------------
   logic        v2_q;
   coeff_t      sum2_q;
   logic [23:0] prod2_q, prod2_d;

   always_comb begin
      prod2_d = 24'(diff1_q) * 24'(zeta1_q);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         v2_q    <= 1'b0;
         sum2_q  <= '0;
         prod2_q <= '0;
      end else begin
         v2_q <= v1_q;
         if (v1_q) begin
            sum2_q  <= sum1_q;
            prod2_q <= prod2_d;
         end
      end
   end

   // ---------------------------------------------------------------------
   // S3: Barrett reduction. BARRETT_M rounds 2^24/Q down, so the quotient
   // estimate may be short by one and the remainder lands in [0, 2Q-1].
   // ---------------------------------------------------------------------
   logic        v3_q;
   coeff_t      sum3_q;
   logic [12:0] r3_q, r3_d;
   logic [36:0] w_bprod;
   logic [12:0] w_qest;
   logic [24:0] w_qq;

   always_comb begin
      w_bprod = {13'd0, prod2_q} * {24'd0, c_M};
      w_qest  = 13'(w_bprod >> 24);
      w_qq    = 25'(w_qest) * 25'(c_Q12);
      // The true remainder fits in 13 bits, so the upper bits are dropped.
      r3_d    = 13'({1'b0, prod2_q} - w_qq);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         v3_q   <= 1'b0;
         sum3_q <= '0;
         r3_q   <= '0;
      end else begin
         v3_q <= v2_q;
         if (v2_q) begin
            sum3_q <= sum2_q;
            r3_q   <= r3_d;
         end
      end
   end

   // ---------------------------------------------------------------------
   // S4: final conditional subtract and output registers. Only a four-stage
   // pipeline exists; other LATENCY values tie the outputs off.
   // ---------------------------------------------------------------------
   generate
      if (LATENCY == 4) begin : g_latency4
         coeff_t b4_d;

         always_comb begin
            b4_d = (r3_q >= c_Q13) ? 12'(r3_q - c_Q13) : 12'(r3_q);
         end

         always_ff @(posedge clk) begin
            if (!rst) begin
               valid_o <= 1'b0;
               a_o     <= '0;
               b_o     <= '0;
            end else begin
               valid_o <= v3_q;
               if (v3_q) begin
                  a_o <= sum3_q;
                  b_o <= b4_d;
               end
            end
         end
      end else begin : g_latency_unsupported
         assign valid_o = 1'b0;
         assign a_o     = '0;
         assign b_o     = '0;
      end
   endgenerate

endmodule
`default_nettype wire
